// File: rtl/mult04_arb_pkg.sv
// rtl/mult04_arb_pkg.sv - shared constants and state type for the mult04 round-robin arbiter
package mult04_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int HOLD_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mult04_rr_pick.sv
// rtl/mult04_rr_pick.sv - combinational rotating-priority picker for four requesters
module mult04_rr_pick
  import mult04_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last_owner,
  output logic               any,
  output logic [SEL_W-1:0]   winner
);

  // Search last_owner+4 down to last_owner+1 so the nearest set bit after last_owner is written last
  always_comb begin
    logic [SEL_W-1:0] idx;
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last_owner + SEL_W'(k);
      if (req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/mult04_rr_arbiter.sv
// rtl/mult04_rr_arbiter.sv - round-robin owner of the 4:1 mux select; optional preemption via MULT04_ARB_TIMEOUT_EN
module mult04_rr_arbiter
  import mult04_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_MAX = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [SEL_W-1:0]   mux_sel,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy
);

  // The select is only two bits wide, so only four requesters can ever be served
  if (NUM_REQ != mult04_arb_pkg::NUM_REQ) begin : g_bad_num_req
    $error("mult04_rr_arbiter: NUM_REQ must be 4");
  end
  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("mult04_rr_arbiter: HOLD_MAX must be in 2..255");
  end

  arb_state_e          state, state_n;
  logic [SEL_W-1:0]    last_owner, last_owner_n;
  logic [SEL_W-1:0]    mux_sel_n;
  logic [NUM_REQ-1:0]  grant_n;
  logic                busy_n;
  logic                pick_any;
  logic [SEL_W-1:0]    pick_winner;

`ifdef MULT04_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
  logic                others_waiting;
  logic                hold_expired;

  assign others_waiting = (req & ~grant) != '0;
  assign hold_expired   = hold_cnt == HOLD_W'(HOLD_MAX - 1);
`endif

  mult04_rr_pick u_pick (
    .req        (req),
    .last_owner (last_owner),
    .any        (pick_any),
    .winner     (pick_winner)
  );

  // State and every output are registers; reset clears grant immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 2'd3;
      mux_sel    <= '0;
      grant      <= '0;
      busy       <= 1'b0;
`ifdef MULT04_ARB_TIMEOUT_EN
      hold_cnt   <= '0;
`endif
    end else begin
      state      <= state_n;
      last_owner <= last_owner_n;
      mux_sel    <= mux_sel_n;
      grant      <= grant_n;
      busy       <= busy_n;
`ifdef MULT04_ARB_TIMEOUT_EN
      hold_cnt   <= hold_cnt_n;
`endif
    end
  end

  // Next state: arbitrate from IDLE/RELEASE, hold or release while in GRANT
  always_comb begin
    state_n      = state;
    last_owner_n = last_owner;
    mux_sel_n    = mux_sel;
    grant_n      = grant;
`ifdef MULT04_ARB_TIMEOUT_EN
    hold_cnt_n   = hold_cnt;
`endif
    case (state)
      GRANT: begin
        if (!req[last_owner]) begin
          state_n = RELEASE;
          grant_n = '0;
        end
`ifdef MULT04_ARB_TIMEOUT_EN
        else if (hold_expired && others_waiting) begin
          state_n = RELEASE;
          grant_n = '0;
        end else if (!hold_expired) begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
`endif
      end
      default: begin
        // IDLE and RELEASE arbitrate identically; mux_sel keeps its value when nobody wins
        if (pick_any) begin
          state_n      = GRANT;
          last_owner_n = pick_winner;
          mux_sel_n    = pick_winner;
          grant_n      = NUM_REQ'(1) << pick_winner;
`ifdef MULT04_ARB_TIMEOUT_EN
          hold_cnt_n   = '0;
`endif
        end else begin
          state_n = IDLE;
          grant_n = '0;
        end
      end
    endcase
    busy_n = (state_n == GRANT);
  end

endmodule
